param_weight_loader: RTL and testbench

// - Producer side of the vector-unit parameter load interface: reads packed param words from param ROM,

---
 rtl/param_weight_loader.sv | 223 ++++++++++++++++++++++
 tb/tb_param_weight_loader.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_weight_loader.sv
// param_weight_loader
// Producer side of the vector-unit parameter load path. Each ROM word is one
// param-FIFO entry {p0,p1,n0,n1}. For every entry the block issues one ROM read,
// shifts the negative pair and then the positive pair onto the byte-lane bus with
// o_prepare_weight, and finally strobes the param-FIFO write. FIFO occupancy is
// tracked with credits (i_set_param pops) so the FIFO is never written when full.
// Build option: define PARAM_LOADER_ROM_REG_EN for a registered-output ROM
// (two-cycle read wait, six-cycle entry cadence). Default is a one-cycle ROM.
//
// Timing note: every output is a registered decode of the state held during the
// previous cycle, so outputs lag the state register by one cycle. The ROM word
// requested in READ is therefore sampled on the edge taken while in NEG.
module param_weight_loader #(
  parameter int PARAM_ROM_ADDR_WIDTH = 8,
  parameter int PARAM_WIDTH          = 26,
  parameter int FIFO_DEPTH           = 32,
  parameter int CNT_WIDTH            = 6
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_start,
  input  logic [PARAM_ROM_ADDR_WIDTH-1:0] i_base_addr,
  input  logic [CNT_WIDTH-1:0]            i_num_entries,
  input  logic                            i_set_param,
  output logic                            o_rom_rd_en,
  output logic [PARAM_ROM_ADDR_WIDTH-1:0] o_rom_addr,
  input  logic [4*PARAM_WIDTH-1:0]        i_rom_data,
  output logic                            o_prepare_weight,
  output logic [7:0]                      o_load_weight_data_a_0,
  output logic [7:0]                      o_load_weight_data_b_0,
  output logic [7:0]                      o_load_weight_data_c_0,
  output logic [7:0]                      o_load_weight_data_d_0,
  output logic [7:0]                      o_load_weight_data_a_1,
  output logic [7:0]                      o_load_weight_data_b_1,
  output logic [7:0]                      o_load_weight_data_c_1,
  output logic [7:0]                      o_load_weight_data_d_1,
  output logic                            o_param_data_fifo_wr_en,
  output logic                            o_busy,
  output logic                            o_done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_NEG   = 3'd3;
  localparam logic [2:0] S_POS   = 3'd4;
  localparam logic [2:0] S_PUSH  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
`ifdef PARAM_LOADER_ROM_REG_EN
  localparam logic [2:0] S_WAIT2 = 3'd7;
`endif

  localparam logic [CNT_WIDTH-1:0]            CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]            CNT_ZERO = CNT_WIDTH'(0);
  localparam logic [CNT_WIDTH-1:0]            FULL_LVL = CNT_WIDTH'(FIFO_DEPTH);
  localparam logic [PARAM_ROM_ADDR_WIDTH-1:0] ADDR_ONE = PARAM_ROM_ADDR_WIDTH'(1);

  // Byte split of one param: a carries only the top two bits.
  function automatic logic [7:0] lane_a(input logic [PARAM_WIDTH-1:0] x);
    lane_a = {6'b000000, x[PARAM_WIDTH-1:PARAM_WIDTH-2]};
  endfunction

  function automatic logic [7:0] lane_b(input logic [PARAM_WIDTH-1:0] x);
    lane_b = x[23:16];
  endfunction

  function automatic logic [7:0] lane_c(input logic [PARAM_WIDTH-1:0] x);
    lane_c = x[15:8];
  endfunction

  function automatic logic [7:0] lane_d(input logic [PARAM_WIDTH-1:0] x);
    lane_d = x[7:0];
  endfunction

  logic [2:0]                      r_state;
  logic [PARAM_ROM_ADDR_WIDTH-1:0] r_addr;
  logic [CNT_WIDTH-1:0]            r_count;
  logic [CNT_WIDTH-1:0]            r_occ;
  logic [2*PARAM_WIDTH-1:0]        r_pos;

  logic [CNT_WIDTH-1:0]            w_occ_next;
  logic                            w_fifo_full;
  logic [PARAM_WIDTH-1:0]          w_src0;
  logic [PARAM_WIDTH-1:0]          w_src1;

  // Credit bookkeeping: a write and a pop in the same cycle cancel; a pop at zero is dropped.
  always_comb begin
    w_occ_next = r_occ;
    if (o_param_data_fifo_wr_en && !i_set_param) begin
      w_occ_next = r_occ + CNT_ONE;
    end else if (!o_param_data_fifo_wr_en && i_set_param && (r_occ != CNT_ZERO)) begin
      w_occ_next = r_occ - CNT_ONE;
    end else begin
      w_occ_next = r_occ;
    end
  end

  // READ looks at the occupancy after this edge so a write landing now is already counted.
  assign w_fifo_full = (w_occ_next == FULL_LVL);

  // Lane source: the negative pair straight from the ROM in NEG, the saved positive pair otherwise.
  always_comb begin
    w_src0 = r_pos[2*PARAM_WIDTH-1:PARAM_WIDTH];
    w_src1 = r_pos[PARAM_WIDTH-1:0];
    if (r_state == S_NEG) begin
      w_src0 = i_rom_data[2*PARAM_WIDTH-1:PARAM_WIDTH];
      w_src1 = i_rom_data[PARAM_WIDTH-1:0];
    end else begin
      w_src0 = r_pos[2*PARAM_WIDTH-1:PARAM_WIDTH];
      w_src1 = r_pos[PARAM_WIDTH-1:0];
    end
  end

  // Param-FIFO occupancy counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ <= CNT_ZERO;
    end else begin
      r_occ <= w_occ_next;
    end
  end

  // Job sequencer and registered strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state                 <= S_IDLE;
      r_addr                  <= '0;
      r_count                 <= CNT_ZERO;
      r_pos                   <= '0;
      o_rom_rd_en             <= 1'b0;
      o_rom_addr              <= '0;
      o_prepare_weight        <= 1'b0;
      o_param_data_fifo_wr_en <= 1'b0;
      o_busy                  <= 1'b0;
      o_done                  <= 1'b0;
    end else begin
      o_rom_rd_en             <= 1'b0;
      o_prepare_weight        <= 1'b0;
      o_param_data_fifo_wr_en <= 1'b0;
      o_done                  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // o_busy is still high in the o_done cycle, which blocks a start there.
          if (i_start && !o_busy) begin
            r_addr  <= i_base_addr;
            r_count <= i_num_entries;
            o_busy  <= 1'b1;
            r_state <= (i_num_entries == CNT_ZERO) ? S_DONE : S_READ;
          end else begin
            o_busy  <= 1'b0;
          end
        end
        S_READ: begin
          if (!w_fifo_full) begin
            o_rom_rd_en <= 1'b1;
            o_rom_addr  <= r_addr;
            r_addr      <= r_addr + ADDR_ONE;
            r_state     <= S_WAIT;
          end else begin
            r_state     <= S_READ;
          end
        end
        S_WAIT: begin
`ifdef PARAM_LOADER_ROM_REG_EN
          r_state <= S_WAIT2;
`else
          r_state <= S_NEG;
`endif
        end
`ifdef PARAM_LOADER_ROM_REG_EN
        S_WAIT2: begin
          r_state <= S_NEG;
        end
`endif
        S_NEG: begin
          o_prepare_weight <= 1'b1;
          r_pos            <= i_rom_data[4*PARAM_WIDTH-1:2*PARAM_WIDTH];
          r_state          <= S_POS;
        end
        S_POS: begin
          o_prepare_weight <= 1'b1;
          r_state          <= S_PUSH;
        end
        S_PUSH: begin
          o_param_data_fifo_wr_en <= 1'b1;
          r_count                 <= r_count - CNT_ONE;
          r_state                 <= (r_count == CNT_ONE) ? S_DONE : S_READ;
        end
        S_DONE: begin
          o_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Byte-lane bus: loaded in NEG and POS, held at every other time.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_load_weight_data_a_0 <= 8'h00;
      o_load_weight_data_b_0 <= 8'h00;
      o_load_weight_data_c_0 <= 8'h00;
      o_load_weight_data_d_0 <= 8'h00;
      o_load_weight_data_a_1 <= 8'h00;
      o_load_weight_data_b_1 <= 8'h00;
      o_load_weight_data_c_1 <= 8'h00;
      o_load_weight_data_d_1 <= 8'h00;
    end else if ((r_state == S_NEG) || (r_state == S_POS)) begin
      o_load_weight_data_a_0 <= lane_a(w_src0);
      o_load_weight_data_b_0 <= lane_b(w_src0);
      o_load_weight_data_c_0 <= lane_c(w_src0);
      o_load_weight_data_d_0 <= lane_d(w_src0);
      o_load_weight_data_a_1 <= lane_a(w_src1);
      o_load_weight_data_b_1 <= lane_b(w_src1);
      o_load_weight_data_c_1 <= lane_c(w_src1);
      o_load_weight_data_d_1 <= lane_d(w_src1);
    end
  end

endmodule

// File: tb/tb_param_weight_loader.sv
// Bench for param_weight_loader: table of single-entry jobs plus hand-written
// sequences for address wrap, start/done overlap, mid-job reset, full-FIFO stall.
module tb_param_weight_loader;

`ifdef PARAM_LOADER_ROM_REG_EN
  localparam int ENT = 6;
`else
  localparam int ENT = 5;
`endif

  logic         clk;
  logic         rst;
  logic         i_start;
  logic [7:0]   i_base_addr;
  logic [5:0]   i_num_entries;
  logic         i_set_param;
  logic         o_rom_rd_en;
  logic [7:0]   o_rom_addr;
  logic [103:0] i_rom_data;
  logic         o_prepare_weight;
  logic [7:0]   a0, b0, c0, d0, a1, b1, c1, d1;
  logic         o_wr;
  logic         o_busy;
  logic         o_done;

  param_weight_loader dut (
    .clk                     (clk),
    .rst                     (rst),
    .i_start                 (i_start),
    .i_base_addr             (i_base_addr),
    .i_num_entries           (i_num_entries),
    .i_set_param             (i_set_param),
    .o_rom_rd_en             (o_rom_rd_en),
    .o_rom_addr              (o_rom_addr),
    .i_rom_data              (i_rom_data),
    .o_prepare_weight        (o_prepare_weight),
    .o_load_weight_data_a_0  (a0),
    .o_load_weight_data_b_0  (b0),
    .o_load_weight_data_c_0  (c0),
    .o_load_weight_data_d_0  (d0),
    .o_load_weight_data_a_1  (a1),
    .o_load_weight_data_b_1  (b1),
    .o_load_weight_data_c_1  (c1),
    .o_load_weight_data_d_1  (d1),
    .o_param_data_fifo_wr_en (o_wr),
    .o_busy                  (o_busy),
    .o_done                  (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model
  logic [103:0] rom [256];
  logic [103:0] rom_q;
  always_ff @(posedge clk) begin
    if (o_rom_rd_en) rom_q <= rom[o_rom_addr];
  end
`ifdef PARAM_LOADER_ROM_REG_EN
  logic [103:0] rom_q2;
  always_ff @(posedge clk) rom_q2 <= rom_q;
  assign i_rom_data = rom_q2;
`else
  assign i_rom_data = rom_q;
`endif

  int checks = 0;
  int failures = 0;
  int n_rd, n_wr, n_prep, n_done;
  logic done_seen;
  logic [7:0]  addr_q [$];
  logic [63:0] prep_q [$];

  typedef struct {
    logic [7:0]   base;
    logic [5:0]   num;
    logic [103:0] word;
    logic [63:0]  neg;
    logic [63:0]  pos;
    int           lat;
  } vec_t;
  vec_t vecs [3];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return {51'd0, o_rom_rd_en, o_rom_addr, o_prepare_weight, o_wr, o_busy, o_done,
            a0, b0, c0, d0, a1, b1, c1, d1};
  endfunction

  task automatic clear_mon();
    n_rd = 0; n_wr = 0; n_prep = 0; n_done = 0;
    addr_q.delete();
    prep_q.delete();
  endtask

  // One clock; outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    done_seen = o_done;
    if (o_rom_rd_en) begin n_rd++; addr_q.push_back(o_rom_addr); end
    if (o_prepare_weight) begin n_prep++; prep_q.push_back({a0, b0, c0, d0, a1, b1, c1, d1}); end
    if (o_wr) n_wr++;
    if (o_done) n_done++;
  endtask

  task automatic go(input logic [7:0] b, input logic [5:0] n, input int limit, output int lat);
    i_base_addr = b; i_num_entries = n; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    lat = 1;
    while (!done_seen && lat < limit) begin
      tick();
      lat++;
    end
    chk("job_done_timeout", 128'(done_seen), 128'd1);
  endtask

  task automatic drain();
    i_set_param = 1'b1;
    repeat (40) tick();
    i_set_param = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int k;
    rst = 1'b1; i_start = 1'b0; i_base_addr = 8'h00; i_num_entries = 6'd0; i_set_param = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 104'd0;
    vecs[0] = '{8'h10, 6'd1, {26'h3FFFFFF, 26'h1234567, 26'h0ABCDEF, 26'h0000000},
                64'h00ABCDEF_00000000, 64'h03FFFFFF_01234567, 2 + ENT};
    vecs[1] = '{8'h20, 6'd1, {26'h2000001, 26'h0FF00FF, 26'h1000000, 26'h3C3C3C3},
                64'h01000000_03C3C3C3, 64'h02000001_00FF00FF, 2 + ENT};
    vecs[2] = '{8'h30, 6'd0, 104'd0, 64'd0, 64'd0, 2};
    clear_mon();

    repeat (3) tick();
    chk("reset_outputs", all_outs(), 128'd0);
    rst = 1'b0;
    tick();
    chk("idle_outputs", all_outs(), 128'd0);

    // Table-driven single jobs
    for (int v = 0; v < 3; v++) begin
      rom[vecs[v].base] = vecs[v].word;
      clear_mon();
      go(vecs[v].base, vecs[v].num, 300, lat);
      chk($sformatf("vec%0d_latency", v), 128'(lat), 128'(vecs[v].lat));
      chk($sformatf("vec%0d_rd", v), 128'(n_rd), 128'(vecs[v].num));
      chk($sformatf("vec%0d_wr", v), 128'(n_wr), 128'(vecs[v].num));
      chk($sformatf("vec%0d_prep", v), 128'(n_prep), 128'(2 * vecs[v].num));
      if (vecs[v].num != 6'd0 && prep_q.size() == 2) begin
        chk($sformatf("vec%0d_addr", v), 128'(addr_q[0]), 128'(vecs[v].base));
        chk($sformatf("vec%0d_neg", v), 128'(prep_q[0]), 128'(vecs[v].neg));
        chk($sformatf("vec%0d_pos", v), 128'(prep_q[1]), 128'(vecs[v].pos));
      end
      tick();
      chk($sformatf("vec%0d_busy_after", v), 128'(o_busy), 128'd0);
      drain();
    end

    // Address wrap
    rom[8'hFE] = {26'h0000011, 26'h0000022, 26'h0000033, 26'h0000044};
    rom[8'hFF] = {26'h0000055, 26'h0000066, 26'h0000077, 26'h0000088};
    rom[8'h00] = {26'h0000001, 26'h0000002, 26'h0000003, 26'h0000004};
    clear_mon();
    go(8'hFE, 6'd3, 300, lat);
    chk("wrap_latency", 128'(lat), 128'(2 + 3 * ENT));
    chk("wrap_rd", 128'(n_rd), 128'd3);
    chk("wrap_wr", 128'(n_wr), 128'd3);
    if (addr_q.size() == 3) begin
      chk("wrap_addr0", 128'(addr_q[0]), 128'h0FE);
      chk("wrap_addr1", 128'(addr_q[1]), 128'h0FF);
      chk("wrap_addr2", 128'(addr_q[2]), 128'h000);
    end
    if (prep_q.size() == 6) begin
      chk("wrap_last_pos", 128'(prep_q[5]), 128'h00000001_00000002);
    end
    // Start in the o_done cycle is ignored
    i_base_addr = 8'h10; i_num_entries = 6'd1; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (4) tick();
    chk("start_at_done_busy", 128'(o_busy), 128'd0);
    chk("start_at_done_rd", 128'(n_rd), 128'd3);
    drain();

    // Reset while entry 2 is on the lane bus
    clear_mon();
    i_base_addr = 8'h40; i_num_entries = 6'd3; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    k = 0;
    while (n_prep < 4 && k < 100) begin tick(); k++; end
    chk("rst_mid_reached", 128'(n_prep), 128'd4);
    rst = 1'b1;
    tick();
    chk("rst_mid_outputs", all_outs(), 128'd0);
    rst = 1'b0;
    repeat (20) tick();
    chk("rst_mid_no_wr", 128'(n_wr), 128'd1);
    chk("rst_mid_no_done", 128'(n_done), 128'd0);
    chk("rst_mid_busy", 128'(o_busy), 128'd0);
    clear_mon();
    go(8'h10, 6'd1, 300, lat);
    chk("rst_restart_latency", 128'(lat), 128'(2 + ENT));
    chk("rst_restart_wr", 128'(n_wr), 128'd1);
    drain();

    // Burst of 32 without pops; a start mid-job is ignored
    clear_mon();
    i_base_addr = 8'h00; i_num_entries = 6'd32; i_start = 1'b1;
    tick();
    lat = 1;
    while (!done_seen && lat < 400) begin
      if (lat == 20) begin
        i_start = 1'b1; i_num_entries = 6'd0; i_base_addr = 8'h80;
      end else begin
        i_start = 1'b0;
      end
      tick();
      lat++;
    end
    i_start = 1'b0;
    chk("burst_done_timeout", 128'(done_seen), 128'd1);
    chk("burst_latency", 128'(lat), 128'(2 + 32 * ENT));
    chk("burst_wr", 128'(n_wr), 128'd32);
    chk("burst_rd", 128'(n_rd), 128'd32);
    repeat (4) tick();
    chk("burst_done_count", 128'(n_done), 128'd1);

    // FIFO full: next job stalls in READ
    clear_mon();
    i_base_addr = 8'h50; i_num_entries = 6'd1; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (20) tick();
    chk("full_stall_rd", 128'(n_rd), 128'd0);
    chk("full_stall_busy", 128'(o_busy), 128'd1);
    // One credit returned -> exactly one entry
    i_set_param = 1'b1;
    tick();
    i_set_param = 1'b0;
    k = 1;
    while (n_wr == 0 && k < 20) begin tick(); k++; end
    chk("from_full_wr", 128'(n_wr), 128'd1);
    chk("from_full_within", 128'(k <= ENT), 128'd1);
    repeat (10) tick();
    chk("from_full_done", 128'(n_done), 128'd1);
    chk("from_full_wr_total", 128'(n_wr), 128'd1);
    // Still full: another job stalls until credits come back
    clear_mon();
    i_base_addr = 8'h51; i_num_entries = 6'd1; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (15) tick();
    chk("refull_stall_rd", 128'(n_rd), 128'd0);
    drain();
    chk("refull_resume_wr", 128'(n_wr), 128'd1);
    chk("refull_resume_done", 128'(n_done), 128'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
